ws2812_rx_decoder: RTL and testbench

//  Receive end of the single-wire WS2812 NRZ link driven by ws2812_top.led_data. Samples the line,

---
 rtl/ws2812_rx_decoder_if.sv | 39 +++
 rtl/ws2812_rx_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_rx_decoder_if.sv
// ws2812_rx_decoder_if
//   Output bundle of the WS2812 receive decoder.
//   Signals:
//     pix_valid   1-cycle strobe, pix_g/r/b/idx valid
//     pix_g/r/b   decoded GRB bytes of the last complete pixel (held)
//     pix_idx     0-based pixel index within the frame, saturates at 255 (held)
//     frame_done  1-cycle strobe at the end of a frame
//     frame_len   pixels in the frame just ended, saturates at 255 (held)
//     err         1-cycle error strobe
//     err_code    01 short pulse, 10 high too long, 11 partial pixel (held)
//     dbg_state   current decoder FSM state (0 SYNC, 1 ARMED, 2 HIGH, 3 LOW)
//   Modports: master = decoder (drives everything), slave = consumer.
//
//   Handshake: every strobe here is valid-only. There is no ready and no
//   back-pressure; a consumer must take pix_valid, frame_done and err on the
//   single cycle they are high. The data fields stay stable until the next
//   strobe of the same kind.
interface ws2812_rx_decoder_if;
    logic       pix_valid;
    logic [7:0] pix_g;
    logic [7:0] pix_r;
    logic [7:0] pix_b;
    logic [7:0] pix_idx;
    logic       frame_done;
    logic [7:0] frame_len;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] dbg_state;

    modport master (
        output pix_valid, pix_g, pix_r, pix_b, pix_idx,
        output frame_done, frame_len, err, err_code, dbg_state
    );

    modport slave (
        input pix_valid, pix_g, pix_r, pix_b, pix_idx,
        input frame_done, frame_len, err, err_code, dbg_state
    );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder
//   Receive side of a WS2812 single-wire NRZ link. Synchronizes the line,
//   measures each high pulse to decode a 0/1 bit, assembles 24-bit GRB pixels
//   (MSB first), detects frame ends from the low reset gap and reports timing
//   violations.
//   Ports:
//     sys_clk    system clock (50 MHz)
//     sys_rst_n  asynchronous active-low reset
//     led_din    serial line, asynchronous to sys_clk
//     rx         output bundle (ws2812_rx_decoder_if.master)
module ws2812_rx_decoder #(
    parameter int unsigned T_HIGH_MIN = 8,
    parameter int unsigned T_THRESH   = 30,
    parameter int unsigned T_HIGH_MAX = 60,
    parameter int unsigned T_RESET    = 2500
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  led_din,
    ws2812_rx_decoder_if.master   rx
);

    localparam int LO_W = $clog2(T_RESET + 1);
    localparam logic [LO_W-1:0] LO_RESET = LO_W'(T_RESET);
    localparam logic [6:0] HI_MIN    = 7'(T_HIGH_MIN);
    localparam logic [6:0] HI_THRESH = 7'(T_THRESH);
    localparam logic [6:0] HI_MAX    = 7'(T_HIGH_MAX);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_ARMED = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q,  prev_d;
    logic [6:0]      hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [23:0]     sr_q, sr_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      pix_cnt_q, pix_cnt_d;

    logic            pix_valid_q, pix_valid_d;
    logic [7:0]      pix_g_q, pix_g_d;
    logic [7:0]      pix_r_q, pix_r_d;
    logic [7:0]      pix_b_q, pix_b_d;
    logic [7:0]      pix_idx_q, pix_idx_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_len_q, frame_len_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic rise;
    logic fall;
    logic hi_too_long;
    logic hi_too_short;
    logic lo_gap_seen;

    // Edge detect runs on the second synchronizer stage against a third flop.
    assign rise         = sync2_q & ~prev_q;
    assign fall         = ~sync2_q & prev_q;
    assign hi_too_long  = (hi_cnt_q > HI_MAX);
    assign hi_too_short = (hi_cnt_q < HI_MIN);
    assign lo_gap_seen  = (lo_cnt_q == LO_RESET);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_g_q      <= '0;
            pix_r_q      <= '0;
            pix_b_q      <= '0;
            pix_idx_q    <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_g_q      <= pix_g_d;
            pix_r_q      <= pix_r_d;
            pix_b_q      <= pix_b_d;
            pix_idx_q    <= pix_idx_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Require the line to still be low so a rising edge landing on the
            // same cycle is not swallowed by the move to ARMED.
            S_SYNC:  if (lo_gap_seen && !sync2_q) state_d = S_ARMED;
            S_ARMED: if (rise) state_d = S_HIGH;
            S_HIGH: begin
                if (hi_too_long || (fall && hi_too_short)) state_d = S_SYNC;
                else if (fall)                             state_d = S_LOW;
            end
            S_LOW: begin
                if (rise)             state_d = S_HIGH;
                else if (lo_gap_seen) state_d = S_ARMED;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // ---------------------------------------------------------------- datapath / output logic
    always_comb begin
        sync1_d      = led_din;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pix_valid_d  = 1'b0;
        pix_g_d      = pix_g_q;
        pix_r_d      = pix_r_q;
        pix_b_d      = pix_b_q;
        pix_idx_d    = pix_idx_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        // The 24th bit landed last cycle: publish the pixel one cycle later so
        // the output bytes come straight from the shift register flops.
        if (bit_cnt_q == 5'd24) begin
            pix_valid_d = 1'b1;
            pix_g_d     = sr_q[23:16];
            pix_r_d     = sr_q[15:8];
            pix_b_d     = sr_q[7:0];
            pix_idx_d   = pix_cnt_q;
            bit_cnt_d   = '0;
            if (pix_cnt_q != 8'hFF) pix_cnt_d = pix_cnt_q + 8'd1;
        end

        case (state_q)
            S_SYNC: begin
                if (sync2_q)           lo_cnt_d = '0;
                else if (!lo_gap_seen) lo_cnt_d = lo_cnt_q + LO_W'(1);
            end
            S_ARMED: begin
                if (rise) hi_cnt_d = '0;
            end
            S_HIGH: begin
                if (hi_too_long || (fall && hi_too_short)) begin
                    // Pulse error: drop the whole frame in progress and resync.
                    err_d      = 1'b1;
                    err_code_d = hi_too_long ? 2'b10 : 2'b01;
                    sr_d       = '0;
                    bit_cnt_d  = '0;
                    pix_cnt_d  = '0;
                    lo_cnt_d   = '0;
                end else if (fall) begin
                    sr_d      = {sr_q[22:0], (hi_cnt_q >= HI_THRESH)};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    lo_cnt_d  = '0;
                end else if (hi_cnt_q != 7'd127) begin
                    hi_cnt_d = hi_cnt_q + 7'd1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    hi_cnt_d = '0;
                end else if (lo_gap_seen) begin
                    if ((pix_cnt_q != 8'd0) || (bit_cnt_q != 5'd0)) begin
                        frame_done_d = 1'b1;
                        frame_len_d  = pix_cnt_q;
                    end
                    if (bit_cnt_q != 5'd0) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b11;
                    end
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end else begin
                    lo_cnt_d = lo_cnt_q + LO_W'(1);
                end
            end
            default: begin
                lo_cnt_d = '0;
            end
        endcase
    end

    assign rx.pix_valid  = pix_valid_q;
    assign rx.pix_g      = pix_g_q;
    assign rx.pix_r      = pix_r_q;
    assign rx.pix_b      = pix_b_q;
    assign rx.pix_idx    = pix_idx_q;
    assign rx.frame_done = frame_done_q;
    assign rx.frame_len  = frame_len_q;
    assign rx.err        = err_q;
    assign rx.err_code   = err_code_q;
    assign rx.dbg_state  = state_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb_ws2812_rx_decoder
//   Drives WS2812 waveforms into ws2812_rx_decoder and checks decoded pixels,
//   frame ends and error strobes against a scoreboard of expected events.
module tb_ws2812_rx_decoder;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int PERIOD = 62;
    localparam int GAP    = 2600;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic led_din;

    ws2812_rx_decoder_if bus ();

    ws2812_rx_decoder dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_din   (led_din),
        .rx        (bus)
    );

    // ---------------------------------------------------------------- clock / cycle counter
    always #10 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- scoreboard state
    logic [31:0] exp_pix_q[$];   // {idx, g, r, b}
    logic [7:0]  exp_len_q[$];
    logic [1:0]  exp_err_q[$];

    int vectors     = 0;
    int miscompares = 0;

    int unsigned last_fall_cyc = 0;
    int unsigned pix_cyc       = 0;
    int unsigned fd_cyc        = 0;
    int unsigned err_cyc       = 0;
    int unsigned rise_cyc      = 0;

    // ---------------------------------------------------------------- driver tasks
    // All drivers start and end 1 time unit after a rising clock edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        int th;
        th = b ? T1H : T0H;
        led_din = 1'b1;
        idle(th);
        led_din = 1'b0;
        last_fall_cyc = cyc;
        idle(PERIOD - th);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input bit push, input logic [7:0] idx);
        if (push) exp_pix_q.push_back({idx, grb});
        for (int i = 23; i >= 0; i--) send_bit(grb[i]);
    endtask

    task automatic end_frame(input bit push, input logic [7:0] len);
        if (push) exp_len_q.push_back(len);
        led_din = 1'b0;
        idle(GAP);
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic monitor();
        logic [31:0] e32;
        logic [7:0]  e8;
        logic [1:0]  e2;
        forever begin
            @(negedge sys_clk);
            if (bus.pix_valid === 1'b1) begin
                pix_cyc = cyc;
                vectors++;
                if (exp_pix_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pix_unexpected: got idx=%0d grb=%02h%02h%02h, required no pixel",
                             bus.pix_idx, bus.pix_g, bus.pix_r, bus.pix_b);
                end else begin
                    e32 = exp_pix_q.pop_front();
                    if ({bus.pix_idx, bus.pix_g, bus.pix_r, bus.pix_b} !== e32) begin
                        miscompares++;
                        $display("FAIL pix_data: got idx=%0d grb=%02h%02h%02h, required idx=%0d grb=%06h",
                                 bus.pix_idx, bus.pix_g, bus.pix_r, bus.pix_b, e32[31:24], e32[23:0]);
                    end
                end
            end
            if (bus.frame_done === 1'b1) begin
                fd_cyc = cyc;
                vectors++;
                if (exp_len_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_unexpected: got frame_len=%0d, required no frame_done", bus.frame_len);
                end else begin
                    e8 = exp_len_q.pop_front();
                    if (bus.frame_len !== e8) begin
                        miscompares++;
                        $display("FAIL frame_len: got %0d, required %0d", bus.frame_len, e8);
                    end
                end
            end
            if (bus.err === 1'b1) begin
                err_cyc = cyc;
                vectors++;
                if (exp_err_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL err_unexpected: got code=%b, required no err", bus.err_code);
                end else begin
                    e2 = exp_err_q.pop_front();
                    if (bus.err_code !== e2) begin
                        miscompares++;
                        $display("FAIL err_code: got %b, required %b", bus.err_code, e2);
                    end
                end
            end
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        led_din   = 1'b0;
        sys_rst_n = 1'b0;
        idle(5);
        vectors++;
        if ({bus.pix_valid, bus.pix_g, bus.pix_r, bus.pix_b, bus.pix_idx,
             bus.frame_done, bus.frame_len, bus.err, bus.err_code} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got pix_valid=%b g=%h r=%h b=%h idx=%h fd=%b len=%h err=%b code=%b, required all 0",
                     bus.pix_valid, bus.pix_g, bus.pix_r, bus.pix_b, bus.pix_idx,
                     bus.frame_done, bus.frame_len, bus.err, bus.err_code);
        end
        vectors++;
        if (bus.dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, required 0 (SYNC)", bus.dbg_state);
        end
        sys_rst_n = 1'b1;
        idle(GAP);
    endtask

    task automatic test_single_pixel();
        pix_cyc = 0;
        send_pixel(24'h0C2238, 1'b1, 8'd0);   // G=12 R=34 B=56
        end_frame(1'b1, 8'd1);
        vectors++;
        if (pix_cyc - last_fall_cyc !== 32'd4) begin
            miscompares++;
            $display("FAIL pix_latency: got %0d cycles, required 4", pix_cyc - last_fall_cyc);
        end
    endtask

    task automatic test_back_to_back();
        send_pixel(24'hFF0000, 1'b1, 8'd0);
        send_pixel(24'h00FF00, 1'b1, 8'd1);
        send_pixel(24'h0000FF, 1'b1, 8'd2);
        end_frame(1'b1, 8'd3);
    endtask

    task automatic test_short_pulse();
        logic [23:0] px;
        px = 24'h5AA596;
        exp_err_q.push_back(2'b01);
        for (int i = 23; i >= 17; i--) send_bit(px[i]);
        led_din = 1'b1;
        idle(5);
        led_din = 1'b0;
        idle(PERIOD - 5);
        for (int i = 15; i >= 0; i--) send_bit(px[i]);
        end_frame(1'b0, 8'd0);                 // resync gap: no frame_done
        send_pixel(24'hA5C33C, 1'b1, 8'd0);
        end_frame(1'b1, 8'd1);
    endtask

    task automatic test_partial_pixel();
        logic [9:0] bits;
        bits = 10'b1011001110;
        err_cyc = 0;
        fd_cyc  = 1;
        exp_err_q.push_back(2'b11);
        for (int i = 9; i >= 0; i--) send_bit(bits[i]);
        end_frame(1'b1, 8'd0);
        vectors++;
        if (err_cyc !== fd_cyc) begin
            miscompares++;
            $display("FAIL partial_same_cycle: got err at %0d frame_done at %0d, required equal", err_cyc, fd_cyc);
        end
    endtask

    task automatic test_long_high();
        err_cyc = 0;
        exp_err_q.push_back(2'b10);
        led_din  = 1'b1;
        rise_cyc = cyc;
        idle(200);
        led_din = 1'b0;
        idle(GAP);
        vectors++;
        if (err_cyc - rise_cyc !== 32'd65) begin
            miscompares++;
            $display("FAIL long_high_timing: got err %0d cycles after rise, required 65", err_cyc - rise_cyc);
        end
        vectors++;
        if (bus.err_code !== 2'b10) begin
            miscompares++;
            $display("FAIL err_code_hold: got %b, required 10", bus.err_code);
        end
        send_pixel(24'h3C0F81, 1'b1, 8'd0);
        end_frame(1'b1, 8'd1);
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] px;
        px = 24'hC0FFEE;
        send_pixel(24'h123456, 1'b1, 8'd0);
        for (int i = 23; i >= 19; i--) send_bit(px[i]);
        led_din = 1'b1;
        idle(10);
        sys_rst_n = 1'b0;
        idle(3);
        vectors++;
        if ({bus.pix_valid, bus.pix_g, bus.pix_r, bus.pix_b, bus.pix_idx,
             bus.frame_done, bus.frame_len, bus.err, bus.err_code} !== 45'd0) begin
            miscompares++;
            $display("FAIL midframe_reset_outputs: got g=%h r=%h b=%h idx=%h len=%h code=%b, required all 0",
                     bus.pix_g, bus.pix_r, bus.pix_b, bus.pix_idx, bus.frame_len, bus.err_code);
        end
        sys_rst_n = 1'b1;
        idle(30);                              // line still high after release
        for (int i = 7; i >= 0; i--) send_bit(px[i]);
        end_frame(1'b0, 8'd0);
        send_pixel(24'h00FF7F, 1'b1, 8'd0);
        end_frame(1'b1, 8'd1);
    endtask

    task automatic test_drain();
        idle(100);
        vectors++;
        if (exp_pix_q.size() != 0) begin
            miscompares++;
            $display("FAIL pix_missing: got %0d pixels outstanding, required 0", exp_pix_q.size());
        end
        vectors++;
        if (exp_len_q.size() != 0) begin
            miscompares++;
            $display("FAIL frame_missing: got %0d frame_done outstanding, required 0", exp_len_q.size());
        end
        vectors++;
        if (exp_err_q.size() != 0) begin
            miscompares++;
            $display("FAIL err_missing: got %0d err outstanding, required 0", exp_err_q.size());
        end
    endtask

    // ---------------------------------------------------------------- sequence and report
    initial begin
        fork
            monitor();
            begin
                test_reset();
                test_single_pixel();
                test_back_to_back();
                test_short_pulse();
                test_partial_pixel();
                test_long_high();
                test_reset_mid_frame();
                test_drain();
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
